// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states and byte-count helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } ls_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Bytes moved by an access; the illegal size code yields 0.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      SIZE_W:  size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of an assembled little-endian load word to register width.
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  output logic [DATA_W-1:0] result
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic signed [7:0] b, input logic uns);
    ext_byte = {{(DATA_W-8){b[7] & ~uns}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic signed [15:0] h, input logic uns);
    ext_half = {{(DATA_W-16){h[15] & ~uns}}, h};
  endfunction

  always_comb begin
    result = word;
    case (ls_size)
      SIZE_B:  result = ext_byte(word[7:0], ls_unsigned);
      SIZE_H:  result = ext_half(word[15:0], ls_unsigned);
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: byte-serial load/store over an 8-bit synchronous memory port.
// Optional misaligned-access rejection is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr_in,
  input  logic              rd_enable_in,
  input  logic [DATA_W-1:0] rd_num_in,
  input  logic              load_en,
  input  logic              store_en,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] store_num,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              stall_req,
  output logic [4:0]        rd_addr_out,
  output logic              rd_enable_out,
  output logic [DATA_W-1:0] rd_num_out,
  output logic              misalign_err
);

  state_e            state;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] load_buf;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] load_result;
  logic [2:0]        n_bytes;
  logic              mem_op;
  logic              misaligned;
  logic              load_req;
  logic              store_req;
  logic              reject;
  logic [ADDR_W-1:0] addr_k;
  logic [1:0]        cap_idx;

  assign n_bytes = size_bytes(ls_size);
  assign mem_op  = (ls_size != SIZE_X);
  assign addr_k  = ls_addr + ADDR_W'(cnt);
  assign cap_idx = cnt[1:0] - 2'd1;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = ((ls_size == SIZE_H) && ls_addr[0]) ||
                      ((ls_size == SIZE_W) && (ls_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Load has priority over store; a rejected request never touches memory.
  assign reject    = (state == ST_IDLE) && (load_en || store_en) && mem_op && misaligned;
  assign load_req  = (state == ST_IDLE) && load_en && mem_op && !misaligned;
  assign store_req = (state == ST_IDLE) && !load_en && store_en && mem_op && !misaligned;

  // The byte arriving this cycle merged into the buffer, so the final byte is usable at once.
  always_comb begin
    load_word = load_buf;
    load_word[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .word        (load_word),
    .ls_size     (ls_size),
    .ls_unsigned (ls_unsigned),
    .result      (load_result)
  );

  always_comb begin
    mem_wr    = 1'b0;
    mem_a     = '0;
    mem_dout  = 8'h00;
    stall_req = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (load_req) begin
            mem_a     = ls_addr;
            stall_req = 1'b1;
          end else if (store_req) begin
            mem_wr    = 1'b1;
            mem_a     = ls_addr;
            mem_dout  = store_num[7:0];
            stall_req = (n_bytes != 3'd1);
          end
        end
        ST_LOAD: begin
          if (cnt < n_bytes) begin
            mem_a     = addr_k;
            stall_req = 1'b1;
          end
        end
        ST_STORE: begin
          mem_wr    = 1'b1;
          mem_a     = addr_k;
          mem_dout  = store_num[{cnt[1:0], 3'b000} +: 8];
          stall_req = (cnt != n_bytes - 3'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= 3'd0;
      load_buf      <= ZERO_WORD;
      rd_addr_out   <= 5'd0;
      rd_enable_out <= 1'b0;
      rd_num_out    <= ZERO_WORD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reject) begin
            rd_enable_out <= 1'b0;
          end else if (load_req) begin
            state         <= ST_LOAD;
            cnt           <= 3'd1;
            rd_enable_out <= 1'b0;
          end else if (store_req) begin
            if (n_bytes == 3'd1) begin
              rd_addr_out   <= 5'd0;
              rd_enable_out <= 1'b0;
              rd_num_out    <= ZERO_WORD;
            end else begin
              state         <= ST_STORE;
              cnt           <= 3'd1;
              rd_enable_out <= 1'b0;
            end
          end else begin
            rd_addr_out   <= rd_addr_in;
            rd_enable_out <= rd_enable_in;
            rd_num_out    <= rd_num_in;
          end
        end
        ST_LOAD: begin
          load_buf <= load_word;
          if (cnt < n_bytes) begin
            cnt           <= cnt + 3'd1;
            rd_enable_out <= 1'b0;
          end else begin
            rd_num_out    <= load_result;
            rd_addr_out   <= rd_addr_in;
            rd_enable_out <= rd_enable_in;
            state         <= ST_IDLE;
            cnt           <= 3'd0;
          end
        end
        ST_STORE: begin
          if (cnt == n_bytes - 3'd1) begin
            rd_addr_out   <= 5'd0;
            rd_enable_out <= 1'b0;
            rd_num_out    <= ZERO_WORD;
            state         <= ST_IDLE;
            cnt           <= 3'd0;
          end else begin
            cnt           <= cnt + 3'd1;
            rd_enable_out <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;
  // Set by a rejected request, cleared by whatever op IDLE accepts next.
  always_ff @(posedge clk) begin
    if (rst)
      misalign_q <= 1'b0;
    else if (state == ST_IDLE)
      misalign_q <= reject;
  end
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM pipeline stage; the consumer of the load/store requests produced by the execute stage.
- Executes byte, half and word loads/stores over an 8-bit synchronous memory port, one byte per cycle.
- Stalls the upstream pipeline while multi-byte accesses are in flight.
- Registers the write-back result (rd address, enable, data) for the WB stage.

Parameters:
- ADDR_W, 32, width of the load/store address and memory address bus.
- DATA_W, 32, width of register data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_in  in  5  destination register from EX.
- rd_enable_in  in  1  destination write enable from EX.
- rd_num_in  in  32  ALU result from EX; passed through when no memory op.
- load_en  in  1  load request from EX.
- store_en  in  1  store request from EX.
- ls_addr  in  32  effective address.
- store_num  in  32  store data; low bytes used.
- ls_size  in  2  access size: 0=byte, 1=half, 2=word; 3 is illegal.
- ls_unsigned  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend.
- mem_din  in  8  memory read byte; valid one cycle after mem_a is presented with mem_wr=0.
- mem_a  out  32  memory byte address (combinational).
- mem_dout  out  8  memory write byte (combinational).
- mem_wr  out  1  1 = write mem_dout to mem_a this cycle.
- stall_req  out  1  combinational; upstream holds all inputs stable while high.
- rd_addr_out  out  5  registered, to WB.
- rd_enable_out  out  1  registered, to WB.
- rd_num_out  out  32  registered, to WB.
- misalign_err  out  1  registered; see Optional Feature.

Behaviour:
- n = bytes of access: 1, 2 or 4. ls_size=3 is treated as a non-memory op (pass-through).
- States: IDLE, LOAD, STORE. Byte counter cnt is 3 bits.
- Byte order is little-endian: byte k lives at ls_addr+k and maps to data bits [8k+7:8k].
- IDLE, neither request:
  - mem_wr=0, mem_a=0, mem_dout=0, stall_req=0.
  - Next edge: rd_*_out <= rd_*_in.
- IDLE, load_en:
  - Present mem_a=ls_addr, mem_wr=0, stall_req=1.
  - Go to LOAD with cnt=1.
- LOAD:
  - Each edge captures mem_din into buffer byte cnt-1.
  - If cnt<n: present mem_a=ls_addr+cnt, stall_req=1, cnt++.
  - If cnt==n: stall_req=0, mem_a=0. Edge registers rd_num_out = extended buffer, rd_addr_out/rd_enable_out from inputs, and returns to IDLE.
  - Latency: n+1 cycles from acceptance; stall_req high for n cycles.
- Sign/zero extension:
  - Byte: bit 7 replicated, or zeros if ls_unsigned.
  - Half: bit 15 replicated, or zeros if ls_unsigned.
  - Word: unchanged.
- IDLE, store_en:
  - mem_wr=1, mem_a=ls_addr, mem_dout=store_num[7:0].
  - If n==1: stall_req=0 and the op completes this cycle.
  - Otherwise: stall_req=1, go to STORE with cnt=1.
- STORE:
  - mem_wr=1, mem_a=ls_addr+cnt, mem_dout=byte cnt of store_num.
  - stall_req=1 until cnt==n-1; stall_req=0 on the last byte, then return to IDLE.
  - Completion edge registers rd_enable_out=0, rd_addr_out=0, rd_num_out=0.
- load_en and store_en both high: load wins, the store is ignored.
- Address arithmetic wraps modulo 2^32; 0xFFFFFFFF+1 -> 0x00000000.
- rst (sync):
  - Takes effect at any state, including mid-access; in-flight access is abandoned.
  - State=IDLE, cnt=0, buffer=0.
  - All registered outputs = 0.
  - Combinational outputs evaluate as IDLE with no request while rst is high: mem_wr=0, mem_a=0, stall_req=0.
- Outputs stay stable between completions; no write-back pulse is generated while stalled. rd_enable_out=0 on every edge where stall_req=1.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - Half with ls_addr[0]!=0, or word with ls_addr[1:0]!=0, is rejected in IDLE: no memory cycle, stall_req=0.
  - Next edge: misalign_err<=1, rd_enable_out<=0. misalign_err clears on the next accepted op.
- Undefined:
  - Misaligned accesses proceed byte-wise normally.
  - misalign_err is tied to 0.

Decomposition:
- Shared package/include (tmp.v): size codes (SIZE_B=0, SIZE_H=1, SIZE_W=2), state encodings, ZERO_WORD.
- One natural sub-module: load_extend (combinational: buffer, ls_size, ls_unsigned -> 32-bit result).
- FSM and counter stay in mem_access_unit.

Test Plan:
- Pass-through: rd_num_in=0x1234, rd_addr_in=5, rd_enable_in=1, no request -> next edge rd_num_out=0x1234, rd_addr_out=5, rd_enable_out=1, stall_req never high.
- LW at 0x100, memory bytes 0x78,0x56,0x34,0x12:
  - mem_a sequence 0x100..0x103.
  - stall_req high 4 cycles.
  - rd_num_out=0x12345678 after 5 cycles.
- LB vs LBU at a byte 0x80: LB -> 0xFFFFFF80, LBU -> 0x00000080. LH of 0x8001 -> 0xFFFF8001.
- SW 0xDEADBEEF at 0x200:
  - mem_wr writes EF,BE,AD,DE to 0x200..0x203.
  - stall 3 cycles, rd_enable_out=0.
- SB 0xAB at 0x7: single mem_wr cycle, stall_req=0.
- rst asserted during LOAD (cnt=2):
  - Next cycle state IDLE, outputs 0, mem_wr=0.
  - A following LW completes correctly.
- MEM_MISALIGN_CHECK_EN: LW at 0x102 -> no mem cycles, misalign_err=1. Without the macro: 4 reads from 0x102..0x105.
